cla32_limb_seq: RTL and testbench
=================================

Name: cla32_limb_seq

Overview:
- Multi-precision add/subtract sequencer that streams arbitrarily long operands through one cla32 instance, one 32-bit limb per clock, least-significant limb first.
- Feeds cla32 its A/B/Cin operands and consumes its S/Cout results, holding the inter-limb carry in a register.
- Registered, backpressure-aware valid/ready stage between the operand source and the result consumer.

Parameters:
- W, 32, limb width; fixed at 32 to match cla32. Other values are unsupported.
- MAX_LIMBS, 8, maximum limbs per packet; sizes the limb counter.
- CW, $clog2(MAX_LIMBS+1), limb counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input limb valid.
- in_ready  out  1  input limb accepted when in_valid && in_ready.
- in_a  in  W  operand A limb.
- in_b  in  W  operand B limb.
- in_first  in  1  limb is least significant of a packet.
- in_last  in  1  limb is most significant of a packet.
- in_cin  in  1  packet carry-in; sampled on first limb only, ignored when in_sub=1.
- in_sub  in  1  1 = A-B; sampled on first limb, held for the packet.
- out_valid  out  1  result limb valid.
- out_ready  in  1  consumer accepts the result limb.
- out_sum  out  W  result limb.
- out_last  out  1  result is the packet's top limb.
- out_cout  out  1  carry out of the top limb; meaningful only with out_last. For sub it is 1 when no borrow occurred.
- out_ovf  out  1  signed overflow of the full packet; meaningful only with out_last.
- out_cnt  out  CW  limb count of the packet; meaningful only with out_last.
- err  out  1  sticky protocol error; cleared only by rst.

Behaviour:
- Reset (async, immediate): out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, out_cnt=0, err=0, carry_q=0, sub_q=0, cnt_q=0, state=IDLE. A packet in flight is discarded. No output appears for it after reset releases.
- Handshake:
  - in_ready = !out_valid || out_ready, so the stage is a single output register with pass-through ready.
  - Beat accepted = in_valid && in_ready.
  - out_* hold stable while out_valid && !out_ready.
- Latency and throughput: the result of an accepted limb appears on out_* the next cycle. Sustains 1 limb/clock with out_ready=1.
- Per accepted beat:
  - Starting limb = in_first, or state==IDLE.
  - sub_e = in_sub on a starting limb, else sub_q.
  - B' = sub_e ? ~in_b : in_b.
  - Cin = starting limb ? (sub_e ? 1 : in_cin) : carry_q.
  - cla32(A=in_a, B=B', Cin) gives S and Cout.
  - Register: out_sum=S, out_last=in_last, out_cout=Cout, carry_q=Cout.
  - out_ovf = (in_a[W-1]==B'[W-1]) && (S[W-1]!=in_a[W-1]).
  - out_cnt = limb index+1, saturating at MAX_LIMBS.
- FSM:
  - IDLE: on accepted beat, go to BUSY if !in_last, else stay IDLE.
  - BUSY: on accepted beat with in_last, go to IDLE.
  - Single-limb packet (first && last) stays in IDLE.
- Boundary conditions:
  - Beat accepted in IDLE without in_first: treated as a first limb, and err is set.
  - in_first in BUSY: aborts the old packet (no out_last is ever issued for it), starts a new packet, and sets err.
  - Limb count reaching MAX_LIMBS without in_last: err is set, cnt saturates, and processing continues unchanged.
  - Carry wrap: all-ones plus 1 propagates the carry across limbs. The final carry is reported only via out_cout.
  - No accepted beat: carry_q, state and the counter hold.
- No combinational path from in_* to out_*. in_ready depends only on out_valid and out_ready.

Decomposition:
- Package cla_pkg: LIMB_W=32, FSM state enum {IDLE, BUSY}, and a result-limb struct {sum, last, cout, ovf, cnt}.
- Sub-module: the existing cla32, instantiated once and unmodified. All sequencing logic stays in cla32_limb_seq.

Test Plan:
- Single limb, A=3, B=10, cin=1, sub=0 -> one cycle later out_sum=14, out_last=1, out_cout=0, out_cnt=1.
- 2-limb add, A=0x00000000_FFFFFFFF, B=0x00000000_00000001, cin=0 -> limb0 sum=0x00000000; limb1 sum=0x00000001, cout=0, cnt=2.
- 2-limb subtract, A=0x00000001_00000000, B=1 -> limb0 0xFFFFFFFF; limb1 0x00000000, cout=1 (no borrow), ovf=0. Then 1-2 single limb -> sum=0xFFFFFFFF, cout=0 (borrow).
- Backpressure: 3-limb packet with out_ready=0 for cycles 2-4 -> in_ready=0 while stalled, out_sum held stable, carry chain correct, no limb lost or duplicated.
- Protocol errors: in_first asserted mid-packet -> err=1 and the new packet computes with a fresh Cin. Separately, 9 limbs with MAX_LIMBS=8 -> err=1 and out_cnt=8.
- Reset asserted asynchronously mid-packet -> outputs go to reset values immediately. A following single-limb packet 0xFFFFFFFF+0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared limb width, sequencer state and result-limb record.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cla_pkg;

    localparam int LIMB_W        = 32;
    localparam int MAX_LIMBS_DEF = 8;
    localparam int CNT_W         = $clog2(MAX_LIMBS_DEF + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [LIMB_W-1:0] sum;
        logic              last;
        logic              cout;
        logic              ovf;
        logic [CNT_W-1:0]  cnt;
    } result_t;

endpackage

`default_nettype wire

// File: rtl/cla32.sv
// ============================================================================
//  Module      : cla32
//  Description : 32-bit carry-lookahead adder, 4-bit lookahead groups.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    localparam int c_groups = 8;

    logic [31:0]         w_g;
    logic [31:0]         w_p;
    logic [31:0]         w_bc;
    logic [c_groups-1:0] w_grp_g;
    logic [c_groups-1:0] w_grp_p;
    logic [c_groups-1:0] w_gc;
    logic                w_cout;

    assign w_g = a & b;
    assign w_p = a ^ b;

    for (genvar i = 0; i < c_groups; i++) begin : g_grp
        logic [3:0] w_gg;
        logic [3:0] w_pp;
        logic       w_ci;

        assign w_gg = w_g[4*i +: 4];
        assign w_pp = w_p[4*i +: 4];
        assign w_ci = w_gc[i];

        assign w_bc[4*i]     = w_ci;
        assign w_bc[4*i + 1] = w_gg[0] | (w_pp[0] & w_ci);
        assign w_bc[4*i + 2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_ci);
        assign w_bc[4*i + 3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                             | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);

        assign w_grp_g[i] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                          | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
        assign w_grp_p[i] = &w_pp;
    end

    // Group carries chain through the per-group generate/propagate terms.
    always_comb begin
        logic c;
        c    = cin;
        w_gc = '0;
        for (int i = 0; i < c_groups; i++) begin
            w_gc[i] = c;
            c       = w_grp_g[i] | (w_grp_p[i] & c);
        end
        w_cout = c;
    end

    assign s    = w_p ^ w_bc;
    assign cout = w_cout;

endmodule

`default_nettype wire

// File: rtl/cla32_limb_seq.sv
// ============================================================================
//  Module      : cla32_limb_seq
//  Description : Multi-precision add/sub sequencer, one 32-bit limb per clock.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cla32_limb_seq
    import cla_pkg::*;
#(
    parameter int W         = LIMB_W,
    parameter int MAX_LIMBS = MAX_LIMBS_DEF,
    parameter int CW        = $clog2(MAX_LIMBS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_first,
    input  logic          in_last,
    input  logic          in_cin,
    input  logic          in_sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_last,
    output logic          out_cout,
    output logic          out_ovf,
    output logic [CW-1:0] out_cnt,
    output logic          err
);

    state_t        r_state;
    logic          r_carry;
    logic          r_sub;
    logic [CW-1:0] r_cnt;
    result_t       r_res;
    logic          r_valid;
    logic          r_err;

    logic          w_accept;
    logic          w_start;
    logic          w_sub_e;
    logic [W-1:0]  w_b;
    logic          w_cin;
    logic [W-1:0]  w_s;
    logic          w_cout;
    logic          w_ovf;
    logic [CW-1:0] w_cnt_next;
    logic          w_err_now;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A stray non-first limb in IDLE is still treated as the start of a packet.
    assign w_start  = in_first || (r_state == IDLE);
    assign w_sub_e  = w_start ? in_sub : r_sub;
    assign w_b      = w_sub_e ? ~in_b : in_b;
    assign w_cin    = w_start ? (w_sub_e ? 1'b1 : in_cin) : r_carry;

    cla32 u_cla32 (
        .a    (in_a),
        .b    (w_b),
        .cin  (w_cin),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_ovf = (in_a[W-1] == w_b[W-1]) && (w_s[W-1] != in_a[W-1]);

    assign w_cnt_next = w_start                   ? CW'(1)
                      : (r_cnt >= CW'(MAX_LIMBS)) ? CW'(MAX_LIMBS)
                      :                             r_cnt + CW'(1);

    assign w_err_now = w_accept &&
                       (((r_state == IDLE) && !in_first) ||
                        ((r_state == BUSY) &&  in_first) ||
                        ((w_cnt_next == CW'(MAX_LIMBS)) && !in_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_res   <= '{sum: w_s, last: in_last, cout: w_cout, ovf: w_ovf,
                             cnt: CNT_W'(w_cnt_next)};
                r_valid <= 1'b1;
                r_carry <= w_cout;
                r_sub   <= w_sub_e;
                r_cnt   <= w_cnt_next;
                case (r_state)
                    IDLE:    r_state <= in_last ? IDLE : BUSY;
                    BUSY:    r_state <= in_last ? IDLE : BUSY;
                    default: r_state <= IDLE;
                endcase
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            r_err <= r_err | w_err_now;
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_res.sum;
    assign out_last  = r_res.last;
    assign out_cout  = r_res.cout;
    assign out_ovf   = r_res.ovf;
    assign out_cnt   = CW'(r_res.cnt);
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cla32_limb_seq.sv
// ============================================================================
//  Module      : tb_cla32_limb_seq
//  Description : Directed self-checking bench for cla32_limb_seq.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cla32_limb_seq;

    localparam int W         = 32;
    localparam int MAX_LIMBS = 8;
    localparam int CW        = $clog2(MAX_LIMBS + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_first;
    logic          in_last;
    logic          in_cin;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_last;
    logic          out_cout;
    logic          out_ovf;
    logic [CW-1:0] out_cnt;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    cla32_limb_seq #(.W(W), .MAX_LIMBS(MAX_LIMBS), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic first, input logic last,
                         input logic cin, input logic sub);
        @(negedge clk);
        in_a = a; in_b = b; in_first = first; in_last = last;
        in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_cin = 1'b0; in_sub = 1'b0;
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.valid: got %b want 0", out_valid); end
        n_cmp++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL reset.sum: got %h want 0", out_sum); end
        n_cmp++; if ({out_last, out_cout, out_ovf} !== 3'b000) begin n_fail++; $display("FAIL reset.flags: got %b want 000", {out_last, out_cout, out_ovf}); end
        n_cmp++; if (out_cnt !== 4'd0) begin n_fail++; $display("FAIL reset.cnt: got %0d want 0", out_cnt); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset.err: got %b want 0", err); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset.in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive(32'd3, 32'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single.valid: got %b want 1", out_valid); end
        n_cmp++; if (out_sum !== 32'd14) begin n_fail++; $display("FAIL single.sum: got %h want 0000000e", out_sum); end
        n_cmp++; if ({out_last, out_cout, out_ovf} !== 3'b100) begin n_fail++; $display("FAIL single.flags: got %b want 100", {out_last, out_cout, out_ovf}); end
        n_cmp++; if (out_cnt !== 4'd1) begin n_fail++; $display("FAIL single.cnt: got %0d want 1", out_cnt); end
        drive(32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_sum !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf.sum: got %h want 80000000", out_sum); end
        n_cmp++; if ({out_cout, out_ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf.flags: got %b want 01", {out_cout, out_ovf}); end
        idle_in();
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single.drain: got %b want 0", out_valid); end
    endtask

    task automatic test_add2();
        drive(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL add2.l0.sum: got %h want 00000000", out_sum); end
        n_cmp++; if ({out_last, out_cout} !== 2'b01) begin n_fail++; $display("FAIL add2.l0.flags: got %b want 01", {out_last, out_cout}); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_sum !== 32'h1) begin n_fail++; $display("FAIL add2.l1.sum: got %h want 00000001", out_sum); end
        n_cmp++; if ({out_last, out_cout} !== 2'b10) begin n_fail++; $display("FAIL add2.l1.flags: got %b want 10", {out_last, out_cout}); end
        n_cmp++; if (out_cnt !== 4'd2) begin n_fail++; $display("FAIL add2.cnt: got %0d want 2", out_cnt); end
        idle_in();
    endtask

    task automatic test_sub();
        drive(32'h0, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (out_sum !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub2.l0.sum: got %h want ffffffff", out_sum); end
        // in_sub deliberately low here: the packet's subtract mode must persist.
        drive(32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL sub2.l1.sum: got %h want 00000000", out_sum); end
        n_cmp++; if ({out_last, out_cout, out_ovf} !== 3'b110) begin n_fail++; $display("FAIL sub2.l1.flags: got %b want 110", {out_last, out_cout, out_ovf}); end
        n_cmp++; if (out_cnt !== 4'd2) begin n_fail++; $display("FAIL sub2.cnt: got %0d want 2", out_cnt); end
        drive(32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (out_sum !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub1.sum: got %h want ffffffff", out_sum); end
        n_cmp++; if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL sub1.flags: got %b want 00", {out_cout, out_ovf}); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL sub.err: got %b want 0", err); end
        idle_in();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_a = 32'hFFFF_FFFF; in_b = 32'h4; in_first = 1'b1; in_last = 1'b0;
        in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_sum !== 32'h3) begin n_fail++; $display("FAIL bp.l0.sum: got %h want 00000003", out_sum); end
        @(negedge clk);
        in_a = 32'hFFFF_FFFF; in_b = 32'h2; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp.in_ready: got %b want 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp.stall%0d.hs: got %b want 10", k, {out_valid, in_ready}); end
            n_cmp++; if (out_sum !== 32'h3) begin n_fail++; $display("FAIL bp.stall%0d.sum: got %h want 00000003", k, out_sum); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_sum !== 32'h2) begin n_fail++; $display("FAIL bp.l1.sum: got %h want 00000002", out_sum); end
        n_cmp++; if ({out_last, out_cout} !== 2'b01) begin n_fail++; $display("FAIL bp.l1.flags: got %b want 01", {out_last, out_cout}); end
        drive(32'h5, 32'h6, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_sum !== 32'hC) begin n_fail++; $display("FAIL bp.l2.sum: got %h want 0000000c", out_sum); end
        n_cmp++; if ({out_last, out_cout} !== 2'b10) begin n_fail++; $display("FAIL bp.l2.flags: got %b want 10", {out_last, out_cout}); end
        n_cmp++; if (out_cnt !== 4'd3) begin n_fail++; $display("FAIL bp.cnt: got %0d want 3", out_cnt); end
        idle_in();
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp.drain: got %b want 0", out_valid); end
    endtask

    task automatic test_errors();
        drive(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL midfirst.pre_err: got %b want 0", err); end
        drive(32'h2, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_sum !== 32'h5) begin n_fail++; $display("FAIL midfirst.sum: got %h want 00000005", out_sum); end
        n_cmp++; if ({out_last, out_cnt} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL midfirst.last_cnt: got %b want 10001", {out_last, out_cnt}); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL midfirst.err: got %b want 1", err); end
        idle_in();

        pulse_reset();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst.err_clear: got %b want 0", err); end
        for (int i = 0; i < 9; i++) begin
            logic [CW-1:0] exp_cnt;
            logic          exp_err;
            exp_cnt = (i + 1 > MAX_LIMBS) ? CW'(MAX_LIMBS) : CW'(i + 1);
            exp_err = (i >= MAX_LIMBS - 1);
            drive(32'(i + 1), 32'h0, (i == 0), (i == 8), 1'b0, 1'b0);
            n_cmp++; if (out_sum !== 32'(i + 1)) begin n_fail++; $display("FAIL max.l%0d.sum: got %h want %h", i, out_sum, 32'(i + 1)); end
            n_cmp++; if (out_cnt !== exp_cnt) begin n_fail++; $display("FAIL max.l%0d.cnt: got %0d want %0d", i, out_cnt, exp_cnt); end
            n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL max.l%0d.err: got %b want %b", i, err, exp_err); end
        end
        n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL max.last: got %b want 1", out_last); end
        idle_in();

        pulse_reset();
        drive(32'h7, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (out_sum !== 32'h9) begin n_fail++; $display("FAIL nofirst.sum: got %h want 00000009", out_sum); end
        n_cmp++; if ({out_cnt, err} !== {4'd1, 1'b1}) begin n_fail++; $display("FAIL nofirst.cnt_err: got %b want 00011", {out_cnt, err}); end
        idle_in();
    endtask

    task automatic test_async_reset();
        drive(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({out_valid, out_cout} !== 2'b11) begin n_fail++; $display("FAIL arst.pre: got %b want 11", {out_valid, out_cout}); end
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_cmp++; if ({out_valid, out_cout, err} !== 3'b000) begin n_fail++; $display("FAIL arst.immediate: got %b want 000", {out_valid, out_cout, err}); end
        n_cmp++; if ({out_sum, out_cnt} !== 36'h0) begin n_fail++; $display("FAIL arst.sum_cnt: got %h want 0", {out_sum, out_cnt}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst.no_stale: got %b want 0", out_valid); end
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (out_sum !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL arst.post.sum: got %h want ffffffff", out_sum); end
        n_cmp++; if ({out_last, out_cout, out_ovf, err} !== 4'b1100) begin n_fail++; $display("FAIL arst.post.flags: got %b want 1100", {out_last, out_cout, out_ovf, err}); end
        n_cmp++; if (out_cnt !== 4'd1) begin n_fail++; $display("FAIL arst.post.cnt: got %0d want 1", out_cnt); end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_single();
        test_add2();
        test_sub();
        test_backpressure();
        test_errors();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
